// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS execute-stage arithmetic units.
// Contents: default divider width, iteration counter width, the divide-by-zero
// quotient pattern and the divider FSM state encoding.
package mips_alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // Quotient returned when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem          in   current partial remainder (always < divisor)
//   dividend_bit in   next dividend bit shifted into the remainder
//   divisor      in   divisor magnitude
//   rem_next     out  partial remainder after the trial subtraction
//   q_bit        out  quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor, so shifted < 2*divisor: a non-negative trial always fits in
  // WIDTH bits and a negative one always sets the top bit.
  assign shifted  = {rem, dividend_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for DIV / DIVU (LO = quotient, HI = remainder).
// Ports:
//   clk, rst (async, active-high)
//   start, is_signed, dividend, divisor  -- request, sampled only in IDLE
//   busy         high while iterating or fixing signs
//   done         one-cycle pulse, results valid
//   quotient, remainder, div_by_zero     -- held until the next completion
// Optional build macro: DIV_EARLY_OUT_EN -- finish in one cycle when the
// divisor magnitude exceeds the dividend magnitude.
module mips_div_unit
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] q_reg;     // shifts dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvsr_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             early_out;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (divisor != '0) && (b_mag > a_mag);
`else
  assign early_out = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_reg),
    .dividend_bit (q_reg[WIDTH-1]),
    .divisor      (dvsr_reg),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      dvsr_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg_q_reg <= a_neg ^ b_neg;
            neg_r_reg <= a_neg;
            dvsr_reg  <= b_mag;
            q_reg     <= a_mag;
            rem_reg   <= '0;
            cnt       <= CNT_W'(WIDTH);
            if (divisor == '0) begin
              quotient    <= WIDTH'(DIV_ZERO_QUOTIENT);
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else if (early_out) begin
              // |divisor| > |dividend|: quotient is zero, remainder is the raw dividend.
              quotient    <= '0;
              remainder   <= dividend;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_reg   <= {q_reg[WIDTH-2:0], step_q};
          rem_reg <= step_rem;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          quotient    <= neg_q_reg ? -q_reg : q_reg;
          remainder   <= neg_r_reg ? -rem_reg : rem_reg;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_vec = 0;
  int n_err = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mips_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic (truncating division, remainder
  // takes the dividend's sign), which also covers -2^31 / -1 without overflow.
  function automatic void model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint sa, sb, qq, rr, ma, mb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
      return;
    end
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    qq = sa / sb;
    rr = sa % sb;
    q  = qq[31:0];
    r  = rr[31:0];
    dz = 1'b0;
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    lat = (EARLY && (mb > ma)) ? 1 : 34;
  endfunction

  // Issue one divide; if poke != 0, assert start with other operands in cycle T+poke.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] eq, er, pq, pr;
    logic        edz, pdz;
    int          elat, lat, busy_err, stab_err;
    model(sg, a, b, eq, er, edz, elat);
    @(negedge clk);
    is_signed = sg; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pq = quotient; pr = remainder; pdz = div_by_zero;
    lat = 1; busy_err = 0; stab_err = 0;
    while (!done && lat < 60) begin
      if (busy !== (lat < elat)) busy_err++;
      if (quotient !== pq || remainder !== pr || div_by_zero !== pdz) stab_err++;
      if (poke != 0 && lat == poke) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    $display("%s %08h / %08h -> q=%08h r=%08h dz=%0b lat=%0d", sg ? "DIV " : "DIVU", a, b,
             quotient, remainder, div_by_zero, lat);
    check("latency", 64'(lat), 64'(elat));
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
    check("busy_at_done", 64'(busy), 64'd0);
    check("busy_profile", 64'(busy_err), 64'd0);
    check("hold_outputs", 64'(stab_err), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic reset_abort();
    int dones;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    $display("reset at T+15 -> q=%08h r=%08h dz=%0b busy=%0b", quotient, remainder, div_by_zero, busy);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rst_no_done", 64'(dones), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    int          mode;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_remainder", 64'(remainder), 64'd0);
    check("reset_dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'd5, 32'd0, 0);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0);
    run_div(1'b0, 32'd3, 32'd9, 0);
    run_div(1'b1, 32'hFFFF_FFFD, 32'd9, 0);
    run_div(1'b0, 32'd50, 32'd5, 10);
    reset_abort();

    for (int n = 0; n < 120; n++) begin
      sg   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        1: b = 32'($urandom_range(1, 300));
        2: b = 32'd0;
        3: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1001, 100000)); end
        4: begin a = 32'h8000_0000; b = (n % 2 == 0) ? 32'hFFFF_FFFF : 32'd1; end
        5: b = -32'($urandom_range(1, 50));
        default: ;
      endcase
      run_div(sg, a, b, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Multi-cycle integer divider for the MIPS execute stage; implements DIV and DIVU and produces LO (quotient) and HI (remainder).
- Restoring algorithm, one quotient bit per cycle. Each iteration is a trial subtraction, so it is the subtract-and-compare counterpart of the single-cycle adder datapath.
- Sits beside the ALU. The pipeline control stalls on busy and captures results on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a divide; accepted only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  in  WIDTH  sampled with start.
- divisor  in  WIDTH  sampled with start.
- busy  out  1  high from the cycle after accept until the cycle before done.
- done  out  1  one-cycle pulse; quotient and remainder are valid in that cycle.
- quotient  out  WIDTH  LO value; held until the next accept.
- remainder  out  WIDTH  HI value; held until the next accept.
- div_by_zero  out  1  valid with done; held until the next accept.

Behaviour:
- Reset (asynchronous, active-high, clock-independent): state = IDLE; busy = 0; done = 0; quotient = 0; remainder = 0; div_by_zero = 0; counter = 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start = 1:
  - Latch operands and is_signed.
  - Signed mode: take the magnitudes and record neg_q = sign(a) ^ sign(b) and neg_r = sign(a).
  - Divisor == 0: go to DONE with quotient = all ones, remainder = dividend (raw), div_by_zero = 1.
  - Otherwise: go to CALC with counter = WIDTH, partial remainder = 0, shift register = |dividend|.
- CALC, each cycle:
  - {rem, q} shifted left 1.
  - Trial = rem - |divisor|, computed at WIDTH+1 bits.
  - Trial non-negative: rem = trial, q[0] = 1. Otherwise: rem unchanged, q[0] = 0.
  - counter decrements; when it reaches 0, go to FIX.
- FIX: negate q if neg_q, negate rem if neg_r (signed mode only); go to DONE.
- DONE: done = 1 for exactly one cycle; go to IDLE.
- Latency:
  - Normal: start accepted in cycle T -> done in cycle T+WIDTH+2 (34 for WIDTH=32).
  - Divide-by-zero: done in cycle T+1.
- busy = (state == CALC) or (state == FIX).
- start while not IDLE: ignored, with no effect on the operation in flight. Start in the same cycle as done is also ignored; it is accepted the next cycle.
- Signed -2^31 / -1: quotient = 0x80000000, remainder = 0, div_by_zero = 0. No trap.
- Remainder sign follows the dividend, and |remainder| < |divisor| always.
- Reset mid-operation: immediate abort to IDLE; no done pulse; outputs cleared.
- Outputs change only at the DONE transition; quotient, remainder and div_by_zero are stable at all other times.

Optional Feature:
- DIV_EARLY_OUT_EN defined: in IDLE, if the divisor is nonzero and |divisor| > |dividend| (unsigned compare of magnitudes), skip CALC.
  - Go directly to DONE with quotient = 0 and remainder = dividend (raw).
  - Latency 1 cycle.
- Undefined: every nonzero divide takes the full WIDTH+2 cycles.
- Results are identical in both builds.

Decomposition:
- Shared package mips_alu_pkg: WIDTH constant, div state enum (IDLE/CALC/FIX/DONE), and the DIV_ZERO_QUOTIENT constant (all ones).
- Sub-module div_step: combinational single restoring step. Inputs rem, shifted dividend bit, divisor. Outputs next rem and quotient bit, using WIDTH+1-bit subtraction.
- The top holds the FSM, counter, registers and sign fix-up.

Test Plan:
- DIVU 100 / 7 -> done in cycle T+34; quotient = 14, remainder = 2, div_by_zero = 0; busy high for cycles T+1..T+33.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> quotient = 0xFFFFFFFD (-3), remainder = 0xFFFFFFFF (-1). Then DIV 7 / -2 -> quotient = -3, remainder = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0. DIVU with the same operands -> quotient = 0, remainder = 0x80000000.
- DIVU 5 / 0 -> done in cycle T+1; quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1.
- Start DIVU 50 / 5; assert start with other operands at T+10 -> ignored, result quotient = 10, remainder = 0. Separately, assert rst at T+15 -> outputs 0 immediately and no done pulse.
- DIV_EARLY_OUT_EN build: DIVU 3 / 9 -> done in cycle T+1, quotient = 0, remainder = 3. Non-EN build: same result in cycle T+34.
